hart_request_dispatcher: RTL and testbench
==========================================

Name: hart_request_dispatcher

Overview:
- Drains the hart request FIFO from its read side (first-word-fall-through head, pop strobe) one entry at a time.
- Issues each entry to the cache core over a req/ready/done handshake.
- Returns a response (read data or write ack) to the hart over a valid/ready handshake.
- Sits between the hart request buffer and the cache core; strictly one request in flight.

Parameters:
BW_ADDR, 32, address width; must match the request buffer.
BW_DATA, 32, data width; must match the request buffer and the cache.
POST_WRITES, 0, 1 = writes complete without a hart response; 0 = every request gets a response.
BW_COUNT, 16, width of the completed-request counter.

Ports:
clock_i  in  1  clock, all state on rising edge
resetn_i  in  1  reset, asynchronous, active-low
buf_empty_i  in  1  request FIFO empty
buf_wren_i  in  1  head entry is a write
buf_addr_i  in  BW_ADDR  head entry address
buf_data_i  in  BW_DATA  head entry write data
buf_read_o  out  1  pop strobe to FIFO, one cycle per entry
cache_req_o  out  1  request valid to cache
cache_wren_o  out  1  request is a write
cache_addr_o  out  BW_ADDR  request address
cache_data_o  out  BW_DATA  request write data
cache_ready_i  in  1  cache accepts request this cycle
cache_done_i  in  1  cache completed accepted request
cache_data_i  in  BW_DATA  read data, valid with cache_done_i
resp_valid_o  out  1  response valid to hart
resp_wren_o  out  1  response is a write ack
resp_data_o  out  BW_DATA  read data (0 for write ack)
resp_ready_i  in  1  hart accepts response
busy_o  out  1  state != IDLE
count_o  out  BW_COUNT  completed requests, wraps modulo 2^BW_COUNT

Behaviour:
- Reset (async assert, synchronous-to-clock release): state=IDLE, all registers 0.
  - All outputs 0 while reset is asserted.
  - Reset mid-operation discards the in-flight request. An entry already popped is lost; the cache must be reset together with this block.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - buf_read_o = !buf_empty_i (combinational; the only combinational output).
  - When buf_read_o=1: latch wren/addr/data into request registers, go to ISSUE.
- ISSUE:
  - cache_req_o=1; cache_wren_o/addr_o/data_o driven from the request registers, held stable until accepted.
  - cache_ready_i=0: stay.
  - cache_ready_i=1 and cache_done_i=0: go to WAIT.
  - cache_ready_i=1 and cache_done_i=1 (zero-wait hit): treat as WAIT completion this cycle.
- WAIT:
  - cache_req_o=0.
  - cache_done_i=1: capture resp_data = wren ? 0 : cache_data_i and resp_wren = wren.
  - Completion target: write with POST_WRITES=1 → IDLE, count+1; otherwise → RESP.
- RESP:
  - resp_valid_o=1; resp_data_o/resp_wren_o held stable.
  - resp_ready_i=1: go to IDLE, count+1.
- Ignored inputs:
  - cache_done_i in IDLE, RESP, or in ISSUE without cache_ready_i.
  - cache_ready_i outside ISSUE.
  - resp_ready_i outside RESP.
- Minimum latency:
  - Pop at cycle 0, cache_req_o at cycle 1.
  - Ready+done at cycle 1 → resp_valid_o at cycle 2.
  - Back-to-back with resp_ready_i tied high: 3 cycles per request; next pop in the IDLE cycle after RESP.
- FIFO empty in IDLE: no pop, busy_o=0.
- count_o: 2^BW_COUNT-1 + 1 wraps to 0, no flag.

Test Plan:
- Read: FIFO holds {wren=0, addr=0x100}; cache ready at cycle 1, done at cycle 3 with 0xDEADBEEF; resp_ready_i=1 → buf_read_o pulses once at cycle 0; resp_valid_o at cycle 4 with data 0xDEADBEEF, resp_wren_o=0; count_o=1.
- Write, POST_WRITES=0 then 1: entry {wren=1, addr=0x40, data=0x55} → cache_data_o=0x55. With 0: ack has resp_wren_o=1, data 0. With 1: no resp_valid_o, count_o increments at done.
- Backpressure: cache_ready_i low for 5 cycles, then resp_ready_i low for 4 cycles → cache_* and resp_* outputs stable throughout; no second pop until the response is accepted.
- Stream: 4 entries, ready/done/resp_ready tied high → pops at cycles 0, 3, 6, 9; responses in FIFO order; count_o=4.
- Reset: assert resetn_i during WAIT → all outputs 0 immediately. After release, spurious cache_done_i is ignored and the next entry is issued normally.
- Wrap: BW_COUNT=2, 5 requests → count_o sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/hart_request_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : hart_request_dispatcher
// Brief    : Pops hart requests from a FWFT FIFO one at a time, issues each to
//            the cache over req/ready/done and returns the read data or write
//            ack to the hart over valid/ready. One request in flight at most.
// Revision : 1.0 - initial release
// ============================================================================
module hart_request_dispatcher #(
  parameter int BW_ADDR     = 32,
  parameter int BW_DATA     = 32,
  parameter int POST_WRITES = 0,
  parameter int BW_COUNT    = 16
) (
  input  logic                clock_i,
  input  logic                resetn_i,
  // request FIFO read side
  input  logic                buf_empty_i,
  input  logic                buf_wren_i,
  input  logic [BW_ADDR-1:0]  buf_addr_i,
  input  logic [BW_DATA-1:0]  buf_data_i,
  output logic                buf_read_o,
  // cache core
  output logic                cache_req_o,
  output logic                cache_wren_o,
  output logic [BW_ADDR-1:0]  cache_addr_o,
  output logic [BW_DATA-1:0]  cache_data_o,
  input  logic                cache_ready_i,
  input  logic                cache_done_i,
  input  logic [BW_DATA-1:0]  cache_data_i,
  // hart response
  output logic                resp_valid_o,
  output logic                resp_wren_o,
  output logic [BW_DATA-1:0]  resp_data_o,
  input  logic                resp_ready_i,
  // status
  output logic                busy_o,
  output logic [BW_COUNT-1:0] count_o
);

  localparam logic                c_post_en    = (POST_WRITES != 0);
  localparam logic [BW_COUNT-1:0] c_count_one  = {{(BW_COUNT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_wren;
  logic [BW_ADDR-1:0]   r_addr;
  logic [BW_DATA-1:0]   r_data;
  logic                 r_resp_wren;
  logic [BW_DATA-1:0]   r_resp_data;
  logic [BW_COUNT-1:0]  r_count;

  logic                 w_pop;
  logic                 w_complete;
  logic                 w_count_inc;
  logic                 w_posted;

  // A write completes silently only when posting is enabled.
  assign w_posted = c_post_en & r_wren;

  // Next-state decode and per-cycle strobes; zero-wait hits in ISSUE are
  // folded into the same completion path as WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_complete  = 1'b0;
    w_count_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!buf_empty_i) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cache_ready_i) begin
          if (cache_done_i) begin
            w_complete = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cache_done_i) begin
          w_complete = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          w_state_nxt = ST_IDLE;
          w_count_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_complete) begin
      if (w_posted) begin
        w_state_nxt = ST_IDLE;
        w_count_inc = 1'b1;
      end else begin
        w_state_nxt = ST_RESP;
      end
    end
  end

  // State register.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the FIFO head when it is popped; held until the next pop.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wren <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_pop) begin
      r_wren <= buf_wren_i;
      r_addr <= buf_addr_i;
      r_data <= buf_data_i;
    end
  end

  // Capture the response at cache completion; write acks carry zero data.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_resp_wren <= 1'b0;
      r_resp_data <= '0;
    end else if (w_complete) begin
      r_resp_wren <= r_wren;
      r_resp_data <= r_wren ? '0 : cache_data_i;
    end
  end

  // Completed-request counter, free-running modulo 2^BW_COUNT.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_count <= '0;
    end else if (w_count_inc) begin
      r_count <= r_count + c_count_one;
    end
  end

  // The pop strobe is the only combinational output; it is forced low while
  // reset is held so nothing is drained during reset.
  assign buf_read_o   = w_pop & resetn_i;

  assign cache_req_o  = (r_state == ST_ISSUE);
  assign cache_wren_o = r_wren;
  assign cache_addr_o = r_addr;
  assign cache_data_o = r_data;

  assign resp_valid_o = (r_state == ST_RESP);
  assign resp_wren_o  = r_resp_wren;
  assign resp_data_o  = r_resp_data;

  assign busy_o       = (r_state != ST_IDLE);
  assign count_o      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_hart_request_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_hart_request_dispatcher
// Brief    : Directed bench for hart_request_dispatcher. d0 uses default
//            parameters, d1 posts writes and has a 2-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hart_request_dispatcher;

  logic        clk;
  logic        rst_n;
  logic        empty0, empty1;
  logic        wren;
  logic [31:0] addr, wdata;
  logic        ready, done;
  logic [31:0] cdata;
  logic        resp_ready;

  logic        d0_pop, d0_req, d0_cwren, d0_rvalid, d0_rwren, d0_busy;
  logic [31:0] d0_caddr, d0_cdata, d0_rdata;
  logic [15:0] d0_count;

  logic        d1_pop, d1_req, d1_cwren, d1_rvalid, d1_rwren, d1_busy;
  logic [31:0] d1_caddr, d1_cdata, d1_rdata;
  logic [1:0]  d1_count;

  int checks   = 0;
  int failures = 0;

  hart_request_dispatcher #(
    .BW_ADDR(32), .BW_DATA(32), .POST_WRITES(0), .BW_COUNT(16)
  ) d0 (
    .clock_i(clk), .resetn_i(rst_n),
    .buf_empty_i(empty0), .buf_wren_i(wren), .buf_addr_i(addr), .buf_data_i(wdata),
    .buf_read_o(d0_pop),
    .cache_req_o(d0_req), .cache_wren_o(d0_cwren), .cache_addr_o(d0_caddr),
    .cache_data_o(d0_cdata), .cache_ready_i(ready), .cache_done_i(done),
    .cache_data_i(cdata),
    .resp_valid_o(d0_rvalid), .resp_wren_o(d0_rwren), .resp_data_o(d0_rdata),
    .resp_ready_i(resp_ready),
    .busy_o(d0_busy), .count_o(d0_count)
  );

  hart_request_dispatcher #(
    .BW_ADDR(32), .BW_DATA(32), .POST_WRITES(1), .BW_COUNT(2)
  ) d1 (
    .clock_i(clk), .resetn_i(rst_n),
    .buf_empty_i(empty1), .buf_wren_i(wren), .buf_addr_i(addr), .buf_data_i(wdata),
    .buf_read_o(d1_pop),
    .cache_req_o(d1_req), .cache_wren_o(d1_cwren), .cache_addr_o(d1_caddr),
    .cache_data_o(d1_cdata), .cache_ready_i(ready), .cache_done_i(done),
    .cache_data_i(cdata),
    .resp_valid_o(d1_rvalid), .resp_wren_o(d1_rwren), .resp_data_o(d1_rdata),
    .resp_ready_i(resp_ready),
    .busy_o(d1_busy), .count_o(d1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; empty0 = 1'b1; empty1 = 1'b1;
    wren = 1'b0; addr = '0; wdata = '0;
    ready = 1'b0; done = 1'b0; cdata = '0; resp_ready = 1'b0;

    // ---------------- reset: outputs low even with a non-empty FIFO
    #2; empty0 = 1'b0; empty1 = 1'b0;
    settle();
    chk("rst_pop0",    32'(d0_pop), 0);
    chk("rst_pop1",    32'(d1_pop), 0);
    chk("rst_busy0",   32'(d0_busy), 0);
    chk("rst_req0",    32'(d0_req), 0);
    chk("rst_rvalid0", 32'(d0_rvalid), 0);
    chk("rst_count0",  32'(d0_count), 0);
    empty0 = 1'b1; empty1 = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    settle();
    chk("idle_empty_pop0",  32'(d0_pop), 0);
    chk("idle_empty_busy0", 32'(d0_busy), 0);

    // ---------------- read with one wait cycle
    empty0 = 1'b0; wren = 1'b0; addr = 32'h100; wdata = '0;
    settle();
    chk("rd_pop_c0", 32'(d0_pop), 1);
    tick();
    empty0 = 1'b1; ready = 1'b1;
    settle();
    chk("rd_req_c1",   32'(d0_req), 1);
    chk("rd_addr_c1",  d0_caddr, 32'h100);
    chk("rd_cwren_c1", 32'(d0_cwren), 0);
    chk("rd_pop_c1",   32'(d0_pop), 0);
    tick();
    ready = 1'b0;
    settle();
    chk("rd_req_c2",  32'(d0_req), 0);
    chk("rd_busy_c2", 32'(d0_busy), 1);
    tick();
    done = 1'b1; cdata = 32'hDEADBEEF;
    settle();
    chk("rd_rvalid_c3", 32'(d0_rvalid), 0);
    tick();
    done = 1'b0; resp_ready = 1'b1;
    settle();
    chk("rd_rvalid_c4", 32'(d0_rvalid), 1);
    chk("rd_rdata_c4",  d0_rdata, 32'hDEADBEEF);
    chk("rd_rwren_c4",  32'(d0_rwren), 0);
    tick();
    resp_ready = 1'b0;
    settle();
    chk("rd_rvalid_c5", 32'(d0_rvalid), 0);
    chk("rd_count_c5",  32'(d0_count), 1);
    chk("rd_busy_c5",   32'(d0_busy), 0);

    // ---------------- write, non-posted, zero-wait hit
    empty0 = 1'b0; wren = 1'b1; addr = 32'h40; wdata = 32'h55;
    settle();
    chk("wr_pop", 32'(d0_pop), 1);
    tick();
    empty0 = 1'b0; wren = 1'b0; addr = 32'h0; wdata = 32'h0;
    empty0 = 1'b1; ready = 1'b1; done = 1'b1; cdata = 32'h99999999;
    settle();
    chk("wr_cdata", d0_cdata, 32'h55);
    chk("wr_cwren", 32'(d0_cwren), 1);
    chk("wr_caddr", d0_caddr, 32'h40);
    tick();
    ready = 1'b0; done = 1'b0; resp_ready = 1'b1;
    settle();
    chk("wr_rvalid", 32'(d0_rvalid), 1);
    chk("wr_rwren",  32'(d0_rwren), 1);
    chk("wr_rdata",  d0_rdata, 32'h0);
    tick();
    resp_ready = 1'b0;
    settle();
    chk("wr_count", 32'(d0_count), 2);

    // ---------------- backpressure from cache, then from hart
    empty0 = 1'b0; wren = 1'b0; addr = 32'h200;
    settle();
    chk("bp_pop_c0", 32'(d0_pop), 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      empty0 = 1'b0; addr = 32'h204; ready = 1'b0; done = 1'b1;
      cdata = 32'hBAD00000 + 32'(i);
      settle();
      chk("bp_issue_req",  32'(d0_req), 1);
      chk("bp_issue_addr", d0_caddr, 32'h200);
      chk("bp_issue_pop",  32'(d0_pop), 0);
      tick();
    end
    ready = 1'b1; done = 1'b1; cdata = 32'h12345678;
    settle();
    chk("bp_accept_req", 32'(d0_req), 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      resp_ready = 1'b0; ready = 1'b1; done = 1'b1;
      cdata = 32'hBAD10000 + 32'(i);
      settle();
      chk("bp_resp_valid", 32'(d0_rvalid), 1);
      chk("bp_resp_data",  d0_rdata, 32'h12345678);
      chk("bp_resp_pop",   32'(d0_pop), 0);
      tick();
    end
    resp_ready = 1'b1;
    settle();
    chk("bp_resp_last", 32'(d0_rvalid), 1);
    tick();

    // ---------------- stream of 4 with handshakes tied high
    settle();
    chk("bp_count", 32'(d0_count), 3);
    for (int i = 0; i < 4; i++) begin
      empty0 = 1'b0; wren = 1'b0; addr = 32'h204 + 32'(4 * i);
      settle();
      chk("st_pop", 32'(d0_pop), 1);
      tick();
      empty0 = 1'b1; cdata = 32'hC0DE0000 + 32'(i);
      settle();
      chk("st_req",  32'(d0_req), 1);
      chk("st_addr", d0_caddr, 32'h204 + 32'(4 * i));
      tick();
      settle();
      chk("st_rvalid", 32'(d0_rvalid), 1);
      chk("st_rdata",  d0_rdata, 32'hC0DE0000 + 32'(i));
      tick();
    end
    ready = 1'b0; done = 1'b0; resp_ready = 1'b0;
    settle();
    chk("st_count", 32'(d0_count), 7);
    chk("st_busy",  32'(d0_busy), 0);

    // ---------------- reset during WAIT
    empty0 = 1'b0; wren = 1'b0; addr = 32'h300;
    settle();
    chk("rw_pop", 32'(d0_pop), 1);
    tick();
    empty0 = 1'b1; ready = 1'b1; done = 1'b0;
    tick();
    ready = 1'b0;
    settle();
    chk("rw_wait_busy", 32'(d0_busy), 1);
    empty0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rw_busy0",   32'(d0_busy), 0);
    chk("rw_req0",    32'(d0_req), 0);
    chk("rw_rvalid0", 32'(d0_rvalid), 0);
    chk("rw_count0",  32'(d0_count), 0);
    chk("rw_caddr0",  d0_caddr, 32'h0);
    chk("rw_pop0",    32'(d0_pop), 0);
    empty0 = 1'b1;
    tick();
    rst_n = 1'b1; done = 1'b1; cdata = 32'h0000FFFF;
    tick();
    done = 1'b0;
    settle();
    chk("rw_spur_busy",   32'(d0_busy), 0);
    chk("rw_spur_rvalid", 32'(d0_rvalid), 0);
    empty0 = 1'b0; addr = 32'h304;
    settle();
    chk("rw_next_pop", 32'(d0_pop), 1);
    tick();
    empty0 = 1'b1; ready = 1'b1; done = 1'b1; cdata = 32'h0000ABCD;
    settle();
    chk("rw_next_req",  32'(d0_req), 1);
    chk("rw_next_addr", d0_caddr, 32'h304);
    tick();
    ready = 1'b0; done = 1'b0; resp_ready = 1'b1;
    settle();
    chk("rw_next_rvalid", 32'(d0_rvalid), 1);
    chk("rw_next_rdata",  d0_rdata, 32'h0000ABCD);
    tick();
    resp_ready = 1'b0;
    settle();
    chk("rw_next_count", 32'(d0_count), 1);

    // ---------------- posted write on d1
    empty1 = 1'b1; empty1 = 1'b0; wren = 1'b1; addr = 32'h40; wdata = 32'h55;
    settle();
    chk("pw_pop", 32'(d1_pop), 1);
    tick();
    empty1 = 1'b1; wren = 1'b0; wdata = '0; ready = 1'b1; done = 1'b0;
    settle();
    chk("pw_req",   32'(d1_req), 1);
    chk("pw_cdata", d1_cdata, 32'h55);
    tick();
    ready = 1'b0;
    settle();
    chk("pw_wait_count", 32'(d1_count), 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    settle();
    chk("pw_rvalid", 32'(d1_rvalid), 0);
    chk("pw_count",  32'(d1_count), 1);
    chk("pw_busy",   32'(d1_busy), 0);

    // ---------------- counter wrap on d1: reads take it 2,3,0,1
    ready = 1'b1; done = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      empty1 = 1'b0; wren = 1'b0; addr = 32'h500 + 32'(i);
      settle();
      chk("wrap_pop", 32'(d1_pop), 1);
      tick();
      empty1 = 1'b1; cdata = 32'h77000000 + 32'(i);
      tick();
      settle();
      chk("wrap_rvalid", 32'(d1_rvalid), 1);
      chk("wrap_rdata",  d1_rdata, 32'h77000000 + 32'(i));
      tick();
      settle();
      chk("wrap_count", 32'(d1_count), 32'((i + 2) % 4));
    end
    ready = 1'b0; done = 1'b0; resp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
